dac_stream_monitor: RTL and testbench

Parametrised DAC-side capture and continuity monitor for the DAC simulation/verification path. Accepts DAC port traffic in parallel (one lane per channel) or interleaved (shared lane, channel select, active-low write) form. Reconstructs per-channel output codes with optional offset-binary inversion. Checks each channel's sample-to-sample step against a programmable limit, with saturating statistics. Sits between the DAC output bus of the generator core and the bench scoreboard/log.

---
 rtl/dac_mon_pkg.sv | 39 +++
 rtl/dac_mon_chan.sv | 113 +++++++++++
 rtl/dac_stream_monitor.sv | 103 ++++++++++
 tb/tb_dac_stream_monitor.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_mon_pkg.sv
// Shared types and helpers for the DAC stream monitor: mode encoding,
// output-code formatting and the no-wrap absolute step between two samples.
package dac_mon_pkg;

    typedef enum logic {
        PAR = 1'b0,
        ILV = 1'b1
    } dac_mode_t;

    // Helpers operate on a fixed wide container; callers zero/sign-extend in
    // and cast the result back down to their own sample width.
    localparam int MAX_DW = 32;

    // Offset-binary inversion keeps the msb and flips every lower bit.
    function automatic logic [MAX_DW-1:0] dac_code(
        input logic [MAX_DW-1:0] d,
        input logic              inv,
        input int                dw
    );
        logic [MAX_DW-1:0] mask;
        mask = (MAX_DW'(1) << (dw - 1)) - MAX_DW'(1);
        return inv ? (d ^ mask) : d;
    endfunction

    // Inputs are already sign-extended two's complement values; the
    // subtraction is done one bit wider so extreme pairs never wrap.
    function automatic logic [MAX_DW:0] abs_step(
        input logic [MAX_DW:0] a,
        input logic [MAX_DW:0] b
    );
        logic [MAX_DW+1:0] diff;
        diff = {a[MAX_DW], a} - {b[MAX_DW], b};
        if (diff[MAX_DW+1]) begin
            diff = -diff;
        end
        return diff[MAX_DW:0];
    endfunction

endpackage

// File: rtl/dac_mon_chan.sv
// One DAC channel: held output code, previous-sample tracking, step checker
// and saturating sample/violation statistics.
module dac_mon_chan
    import dac_mon_pkg::*;
#(
    parameter int DW = 14,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [DW-1:0] dat,
    input  logic          inv,
    input  logic          chk_en,
    input  logic          clr,
    input  logic [DW-1:0] step_lim,
    output logic [DW-1:0] code,
    output logic          vld,
    output logic          err,
    output logic [CW-1:0] err_cnt,
    output logic [CW-1:0] smp_cnt,
    output logic [CW-1:0] first_err
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [DW-1:0] prev_reg,      prev_next;
    logic          prev_vld_reg,  prev_vld_next;
    logic [DW-1:0] code_reg,      code_next;
    logic          vld_reg,       vld_next;
    logic          err_reg,       err_next;
    logic [CW-1:0] err_cnt_reg,   err_cnt_next;
    logic [CW-1:0] smp_cnt_reg,   smp_cnt_next;
    logic [CW-1:0] first_err_reg, first_err_next;

    logic [DW-1:0] code_new;
    logic [DW:0]   step;
    logic          viol;

    assign code_new = DW'(dac_code(MAX_DW'(dat), inv, DW));
    assign step     = (DW+1)'(abs_step({{(MAX_DW+1-DW){dat[DW-1]}}, dat},
                                       {{(MAX_DW+1-DW){prev_reg[DW-1]}}, prev_reg}));
    assign viol     = wr && chk_en && prev_vld_reg && (step > {1'b0, step_lim});

    always_comb begin
        prev_next      = prev_reg;
        prev_vld_next  = prev_vld_reg;
        code_next      = code_reg;
        vld_next       = wr;
        err_next       = err_reg;
        err_cnt_next   = err_cnt_reg;
        smp_cnt_next   = smp_cnt_reg;
        first_err_next = first_err_reg;

        if (clr) begin
            // A write coincident with clear starts the fresh history unchecked.
            err_next       = 1'b0;
            err_cnt_next   = '0;
            first_err_next = '0;
            smp_cnt_next   = wr ? CW'(1) : '0;
            prev_vld_next  = wr;
        end else if (wr) begin
            prev_vld_next = 1'b1;
            if (smp_cnt_reg != CNT_MAX) begin
                smp_cnt_next = smp_cnt_reg + CW'(1);
            end
            if (viol) begin
                err_next = 1'b1;
                if (err_cnt_reg == '0) begin
                    first_err_next = smp_cnt_reg;
                end
                if (err_cnt_reg != CNT_MAX) begin
                    err_cnt_next = err_cnt_reg + CW'(1);
                end
            end
        end

        if (wr) begin
            prev_next = dat;
            code_next = code_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg      <= '0;
            prev_vld_reg  <= 1'b0;
            code_reg      <= '0;
            vld_reg       <= 1'b0;
            err_reg       <= 1'b0;
            err_cnt_reg   <= '0;
            smp_cnt_reg   <= '0;
            first_err_reg <= '0;
        end else begin
            prev_reg      <= prev_next;
            prev_vld_reg  <= prev_vld_next;
            code_reg      <= code_next;
            vld_reg       <= vld_next;
            err_reg       <= err_next;
            err_cnt_reg   <= err_cnt_next;
            smp_cnt_reg   <= smp_cnt_next;
            first_err_reg <= first_err_next;
        end
    end

    assign code      = code_reg;
    assign vld       = vld_reg;
    assign err       = err_reg;
    assign err_cnt   = err_cnt_reg;
    assign smp_cnt   = smp_cnt_reg;
    assign first_err = first_err_reg;

endmodule

// File: rtl/dac_stream_monitor.sv
// DAC-side capture and continuity monitor: decodes parallel or interleaved
// write traffic into per-channel checkers and flags out-of-range selects.
module dac_stream_monitor
    import dac_mon_pkg::*;
#(
    parameter int CHN  = 2,
    parameter int DW   = 14,
    parameter int CW   = 16,
    parameter int SELW = (CHN > 1) ? $clog2(CHN) : 1
) (
    input  logic              dac_clk_i,
    input  logic              dac_rstn_i,
    input  logic              mode_i,
    input  logic              inv_i,
    input  logic              chk_en_i,
    input  logic              clr_i,
    input  logic [DW-1:0]     step_lim_i,
    input  logic [CHN*DW-1:0] dac_dat_i,
    input  logic [CHN-1:0]    dac_wrt_i,
    input  logic [SELW-1:0]   dac_sel_i,
    output logic [CHN*DW-1:0] dac_o,
    output logic [CHN-1:0]    vld_o,
    output logic [CHN-1:0]    err_o,
    output logic [CHN*CW-1:0] err_cnt_o,
    output logic [CHN*CW-1:0] smp_cnt_o,
    output logic [CHN*CW-1:0] first_err_o,
    output logic              sel_err_o
);

    dac_mode_t      mode;
    logic [CHN-1:0] wr;
    logic           sel_hit;
    logic           sel_bad;
    logic           sel_err_reg, sel_err_next;

    assign mode = dac_mode_t'(mode_i);

    // Interleaved writes are active-low on bit 0 and steered by the select.
    always_comb begin
        wr      = '0;
        sel_hit = 1'b0;
        sel_bad = 1'b0;
        if (mode == ILV) begin
            if (!dac_wrt_i[0]) begin
                for (int n = 0; n < CHN; n++) begin
                    if (dac_sel_i == SELW'(n)) begin
                        wr[n]   = 1'b1;
                        sel_hit = 1'b1;
                    end
                end
                sel_bad = !sel_hit;
            end
        end else begin
            wr = dac_wrt_i;
        end
    end

    always_comb begin
        sel_err_next = sel_err_reg | sel_bad;
        if (clr_i) begin
            sel_err_next = sel_bad;
        end
    end

    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            sel_err_reg <= 1'b0;
        end else begin
            sel_err_reg <= sel_err_next;
        end
    end

    assign sel_err_o = sel_err_reg;

    generate
        for (genvar gi = 0; gi < CHN; gi++) begin : g_chan
            logic [DW-1:0] lane_dat;

            assign lane_dat = (mode == ILV) ? dac_dat_i[DW-1:0] : dac_dat_i[gi*DW +: DW];

            dac_mon_chan #(
                .DW (DW),
                .CW (CW)
            ) u_chan (
                .clk       (dac_clk_i),
                .rst_n     (dac_rstn_i),
                .wr        (wr[gi]),
                .dat       (lane_dat),
                .inv       (inv_i),
                .chk_en    (chk_en_i),
                .clr       (clr_i),
                .step_lim  (step_lim_i),
                .code      (dac_o[gi*DW +: DW]),
                .vld       (vld_o[gi]),
                .err       (err_o[gi]),
                .err_cnt   (err_cnt_o[gi*CW +: CW]),
                .smp_cnt   (smp_cnt_o[gi*CW +: CW]),
                .first_err (first_err_o[gi*CW +: CW])
            );
        end
    endgenerate

endmodule

// File: tb/tb_dac_stream_monitor.sv
// Scoreboard bench for dac_stream_monitor (CHN=2, DW=14, CW=4, SELW=2):
// directed writes push hand-computed expectations, a monitor pops on vld_o.
module tb_dac_stream_monitor;

    localparam int CHN  = 2;
    localparam int DW   = 14;
    localparam int CW   = 4;
    localparam int SELW = 2;

    logic              clk;
    logic              rst_n;
    logic              mode;
    logic              inv;
    logic              chk_en;
    logic              clr;
    logic [DW-1:0]     step_lim;
    logic [CHN*DW-1:0] dat;
    logic [CHN-1:0]    wrt;
    logic [SELW-1:0]   sel;
    logic [CHN*DW-1:0] dac;
    logic [CHN-1:0]    vld;
    logic [CHN-1:0]    err;
    logic [CHN*CW-1:0] err_cnt;
    logic [CHN*CW-1:0] smp_cnt;
    logic [CHN*CW-1:0] first_err;
    logic              sel_err;

    typedef struct {
        int            ch;
        logic [DW-1:0] code;
        logic          err;
        int            ec;
        int            sc;
        int            fe;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    dac_stream_monitor #(
        .CHN  (CHN),
        .DW   (DW),
        .CW   (CW),
        .SELW (SELW)
    ) dut (
        .dac_clk_i   (clk),
        .dac_rstn_i  (rst_n),
        .mode_i      (mode),
        .inv_i       (inv),
        .chk_en_i    (chk_en),
        .clr_i       (clr),
        .step_lim_i  (step_lim),
        .dac_dat_i   (dat),
        .dac_wrt_i   (wrt),
        .dac_sel_i   (sel),
        .dac_o       (dac),
        .vld_o       (vld),
        .err_o       (err),
        .err_cnt_o   (err_cnt),
        .smp_cnt_o   (smp_cnt),
        .first_err_o (first_err),
        .sel_err_o   (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int ch, input logic [DW-1:0] code, input logic e,
                        input int ec, input int sc, input int fe);
        exp_t x;
        x.ch = ch; x.code = code; x.err = e; x.ec = ec; x.sc = sc; x.fe = fe;
        q.push_back(x);
    endtask

    task automatic cyc(input logic [1:0] w, input logic [SELW-1:0] s, input logic [DW-1:0] d0,
                       input logic [DW-1:0] d1, input logic c, input logic [DW-1:0] lim);
        @(negedge clk);
        wrt = w; sel = s; dat = {d1, d0}; clr = c; step_lim = lim;
    endtask

    task automatic idle();
        @(negedge clk);
        wrt = mode ? 2'b11 : 2'b00; clr = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        wrt = mode ? 2'b11 : 2'b00; clr = 1'b1;
    endtask

    task automatic set_mode(input logic m);
        @(negedge clk);
        mode = m; wrt = m ? 2'b11 : 2'b00; clr = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dac"}, 64'(dac), 0);
        check({tag, "_vld"}, 64'(vld), 0);
        check({tag, "_err"}, 64'(err), 0);
        check({tag, "_err_cnt"}, 64'(err_cnt), 0);
        check({tag, "_smp_cnt"}, 64'(smp_cnt), 0);
        check({tag, "_first_err"}, 64'(first_err), 0);
        check({tag, "_sel_err"}, 64'(sel_err), 0);
    endtask

    // Monitor: every vld_o pulse must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int n = 0; n < CHN; n++) begin
                if (vld[n] === 1'b1) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_vld: ch%0d pulsed with code 0x%0h, expected no write",
                                 n, dac[n*DW +: DW]);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("ch%0d_channel", n), 64'(n), 64'(e.ch));
                        check($sformatf("ch%0d_dac", n), 64'(dac[n*DW +: DW]), 64'(e.code));
                        check($sformatf("ch%0d_err", n), 64'(err[n]), 64'(e.err));
                        check($sformatf("ch%0d_err_cnt", n), 64'(err_cnt[n*CW +: CW]), 64'(e.ec));
                        check($sformatf("ch%0d_smp_cnt", n), 64'(smp_cnt[n*CW +: CW]), 64'(e.sc));
                        check($sformatf("ch%0d_first_err", n), 64'(first_err[n*CW +: CW]), 64'(e.fe));
                        $display("txn ch%0d code=0x%0h err=%0d err_cnt=%0d smp_cnt=%0d first_err=%0d",
                                 n, dac[n*DW +: DW], err[n], err_cnt[n*CW +: CW],
                                 smp_cnt[n*CW +: CW], first_err[n*CW +: CW]);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        rst_n = 1'b1; mode = 1'b0; inv = 1'b0; chk_en = 1'b1; clr = 1'b0;
        step_lim = 14'd1; dat = '0; wrt = '0; sel = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        inv   = 1'b1;

        // Parallel, both channels at once, offset-binary inversion.
        cyc(2'b11, 2'd0, 14'h0005, 14'h2000, 1'b0, 14'd1);
        push(0, 14'h1FFA, 1'b0, 0, 1, 0);
        push(1, 14'h3FFF, 1'b0, 0, 1, 0);
        idle();
        inv = 1'b0;
        do_clr();

        // Interleaved, alternating select, +1 per channel; lane 1 and wrt[1] ignored.
        set_mode(1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(2'b00, 2'd0, 14'(16 + i), 14'h3ABC, 1'b0, 14'd1);
            push(0, 14'(16 + i), 1'b0, 0, i + 1, 0);
            cyc(2'b10, 2'd1, 14'(32 + i), 14'h3ABC, 1'b0, 14'd1);
            push(1, 14'(32 + i), 1'b0, 0, i + 1, 0);
        end
        idle();
        set_mode(1'b0);
        do_clr();

        // Step violations on ch0: ramp 0,1,2,10,11,12.
        cyc(2'b01, 2'd0, 14'd0,  14'h1234, 1'b0, 14'd1); push(0, 14'd0,  1'b0, 0, 1, 0);
        cyc(2'b01, 2'd0, 14'd1,  14'h1234, 1'b0, 14'd1); push(0, 14'd1,  1'b0, 0, 2, 0);
        cyc(2'b01, 2'd0, 14'd2,  14'h1234, 1'b0, 14'd1); push(0, 14'd2,  1'b0, 0, 3, 0);
        cyc(2'b01, 2'd0, 14'd10, 14'h1234, 1'b0, 14'd1); push(0, 14'd10, 1'b1, 1, 4, 3);
        cyc(2'b01, 2'd0, 14'd11, 14'h1234, 1'b0, 14'd1); push(0, 14'd11, 1'b1, 1, 5, 3);
        cyc(2'b01, 2'd0, 14'd12, 14'h1234, 1'b0, 14'd1); push(0, 14'd12, 1'b1, 1, 6, 3);
        // 12 -> 0x1FFF is 8179 (legal at limit 8191); 0x1FFF -> 0x2000 is 16383 (no wrap).
        cyc(2'b01, 2'd0, 14'h1FFF, 14'h1234, 1'b0, 14'h1FFF); push(0, 14'h1FFF, 1'b1, 1, 7, 3);
        cyc(2'b01, 2'd0, 14'h2000, 14'h1234, 1'b0, 14'h1FFF); push(0, 14'h2000, 1'b1, 2, 8, 3);
        idle();
        chk_en = 1'b0;
        cyc(2'b01, 2'd0, 14'd0, 14'h1234, 1'b0, 14'd1); push(0, 14'd0, 1'b1, 2, 9, 3);
        idle();
        chk_en = 1'b1;
        // Compared against the sample accepted while checking was off: step 3 > 2.
        cyc(2'b01, 2'd0, 14'd3, 14'h1234, 1'b0, 14'd2); push(0, 14'd3, 1'b1, 3, 10, 3);
        // Step exactly at the limit is legal.
        cyc(2'b01, 2'd0, 14'd5, 14'h1234, 1'b0, 14'd2); push(0, 14'd5, 1'b1, 3, 11, 3);

        // Clear together with a write, then a legal follow-up.
        cyc(2'b01, 2'd0, 14'd100, 14'h1234, 1'b1, 14'd1); push(0, 14'd100, 1'b0, 0, 1, 0);
        cyc(2'b01, 2'd0, 14'd101, 14'h1234, 1'b0, 14'd1); push(0, 14'd101, 1'b0, 0, 2, 0);
        idle();
        do_clr();
        cyc(2'b01, 2'd0, 14'd500, 14'h1234, 1'b0, 14'd1); push(0, 14'd500, 1'b0, 0, 1, 0);

        // Saturation on ch1: 20 writes alternating 0/0x100, each after the first violates.
        for (int i = 0; i < 20; i++) begin
            d = (i % 2 == 1) ? 14'h0100 : 14'h0000;
            cyc(2'b10, 2'd0, 14'h3333, d, 1'b0, 14'd1);
            push(1, d, (i >= 1), (i < 15) ? i : 15, (i + 1 < 15) ? i + 1 : 15, (i >= 1) ? 1 : 0);
        end
        idle();

        // Out-of-range interleaved select: dropped, sticky flag.
        set_mode(1'b1);
        cyc(2'b10, 2'd3, 14'h0777, 14'h0777, 1'b0, 14'd1);
        idle();
        check("sel_err_set", 64'(sel_err), 1);
        check("sel_drop_dac", 64'(dac), 64'({14'h0100, 14'd500}));
        idle();
        check("sel_err_sticky", 64'(sel_err), 1);
        do_clr();
        idle();
        check("clr_sel_err", 64'(sel_err), 0);
        check("clr_smp_cnt", 64'(smp_cnt), 0);
        check("clr_err_cnt", 64'(err_cnt), 0);
        check("clr_keeps_dac", 64'(dac), 64'({14'h0100, 14'd500}));

        // Reset mid-stream: the write in the reset cycle is discarded.
        set_mode(1'b0);
        cyc(2'b01, 2'd0, 14'h0050, 14'h0000, 1'b0, 14'd1); push(0, 14'h0050, 1'b0, 0, 1, 0);
        cyc(2'b01, 2'd0, 14'h0060, 14'h0000, 1'b0, 14'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        idle();
        rst_n = 1'b1;
        cyc(2'b01, 2'd0, 14'h0070, 14'h0000, 1'b0, 14'd0); push(0, 14'h0070, 1'b0, 0, 1, 0);
        cyc(2'b01, 2'd0, 14'h0071, 14'h0000, 1'b0, 14'd0); push(0, 14'h0071, 1'b1, 1, 2, 1);
        idle();
        idle();
        idle();
        check("scoreboard_drained", 64'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
